// File: rtl/tpu_fc_pkg.sv
// Shared constants, FSM state codes and arithmetic helpers for the FC layer engines.
// Consumed by fc_layer_engine and fc_requant; holds no logic of its own.
package tpu_fc_pkg;

    localparam int FC_DW    = 16;
    localparam int FC_FRAC  = 8;
    localparam int FC_LANES = 128;
    localparam int FC_AW    = 11;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_WB    = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // Clamp a wide signed value into the range of a w-bit signed number.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/fc_requant.sv
// Requantise a Q(2*FRAC) accumulator to Q(FRAC): floor shift, saturate, optional ReLU (FC_RELU_EN).
// Latency: combinational.
// Backpressure: none, pure function of acc.
module fc_requant
    import tpu_fc_pkg::*;
#(
    parameter int ACC_W = 33,
    parameter int DW    = FC_DW,
    parameter int FRAC  = FC_FRAC
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic        [DW-1:0]    q
);

    logic signed [63:0] wide;
    logic signed [63:0] shifted;
    logic signed [63:0] sat;

    assign wide    = 64'(acc);
    assign shifted = wide >>> FRAC;
    assign sat     = saturate(shifted, DW);

`ifdef FC_RELU_EN
    assign q = (sat < 0) ? '0 : DW'(sat);
`else
    assign q = DW'(sat);
`endif

endmodule

// File: rtl/fc_layer_engine.sv
// Fully-connected layer: streams weight rows per neuron, accumulates, requantises (ReLU under FC_RELU_EN).
// Latency: done 1 + OUT_LEN*(2*CHUNKS+1) edges after ena is first sampled in IDLE.
// Backpressure: none; ena low before DONE aborts to IDLE, done holds until iRst_n.
module fc_layer_engine
    import tpu_fc_pkg::*;
#(
    parameter int IN_LEN   = 128,
    parameter int OUT_LEN  = 128,
    parameter int IN_W     = 16,
    parameter int DW       = FC_DW,
    parameter int FRAC     = FC_FRAC,
    parameter int LANES    = FC_LANES,
    parameter int AW       = FC_AW,
    parameter int ROM_BASE = 0
) (
    input  logic                   clk,
    input  logic                   iRst_n,
    input  logic                   ena,
    input  logic [LANES*DW-1:0]    data_from_rom,
    input  logic [IN_LEN*IN_W-1:0] data_from_ram,
    input  logic [2*DW-2:0]        data_from_MultAdder,
    output logic                   done,
    output logic [AW-1:0]          addr_to_rom,
    output logic [LANES*DW-1:0]    opr1_to_MultAdder,
    output logic [LANES*DW-1:0]    opr2_to_MultAdder,
    output logic [OUT_LEN*DW-1:0]  data_to_ram
);

    localparam int CHUNKS = (IN_LEN + LANES - 1) / LANES;
    localparam int ACC_W  = 2*DW + clog2(CHUNKS) + 1;
    localparam int JW     = (clog2(OUT_LEN) < 1) ? 1 : clog2(OUT_LEN);
    localparam int CW     = (clog2(CHUNKS) < 1) ? 1 : clog2(CHUNKS);

    logic [2:0]               state;
    logic [JW-1:0]            j_cnt;
    logic [CW-1:0]            c_cnt;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  mac_ext;
    logic [CHUNKS*LANES*DW-1:0] in_exp;
    logic [DW-1:0]            rq;
    logic                     last_chunk;
    logic                     last_neuron;
    logic                     abort;

    function automatic logic [AW-1:0] row_addr(input int j, input int c);
        return AW'(ROM_BASE + j*CHUNKS + c);
    endfunction

    // Input vector expanded to DW lanes and zero-padded to a whole number of chunks.
    for (genvar k = 0; k < CHUNKS*LANES; k++) begin : g_lane
        if (k >= IN_LEN) begin : g_pad
            assign in_exp[k*DW +: DW] = '0;
        end else if (IN_W == 1) begin : g_bin
            assign in_exp[k*DW +: DW] = data_from_ram[k] ? DW'(1 << FRAC) : '0;
        end else begin : g_fix
            assign in_exp[k*DW +: DW] = data_from_ram[k*IN_W +: IN_W];
        end
    end

    assign mac_ext     = ACC_W'($signed(data_from_MultAdder));
    assign last_chunk  = (int'(c_cnt) == CHUNKS - 1);
    assign last_neuron = (int'(j_cnt) == OUT_LEN - 1);
    assign abort       = !ena && (state != S_IDLE) && (state != S_DONE);

    assign opr1_to_MultAdder = (state == S_MAC) ? data_from_rom : '0;
    assign opr2_to_MultAdder = (state == S_MAC) ? in_exp[c_cnt*LANES*DW +: LANES*DW] : '0;

    fc_requant #(
        .ACC_W (ACC_W),
        .DW    (DW),
        .FRAC  (FRAC)
    ) u_requant (
        .acc (acc),
        .q   (rq)
    );

    always_ff @(posedge clk or negedge iRst_n) begin
        if (!iRst_n) begin
            state       <= S_IDLE;
            done        <= 1'b0;
            addr_to_rom <= '0;
            j_cnt       <= '0;
            c_cnt       <= '0;
            acc         <= '0;
        end else if (abort) begin
            state       <= S_IDLE;
            addr_to_rom <= '0;
            j_cnt       <= '0;
            c_cnt       <= '0;
            acc         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ena) begin
                        state       <= S_ISSUE;
                        addr_to_rom <= row_addr(0, 0);
                        j_cnt       <= '0;
                        c_cnt       <= '0;
                        acc         <= '0;
                    end
                end
                S_ISSUE: state <= S_MAC;
                S_MAC: begin
                    acc <= acc + mac_ext;
                    if (!last_chunk) begin
                        c_cnt       <= c_cnt + 1'b1;
                        addr_to_rom <= row_addr(int'(j_cnt), int'(c_cnt) + 1);
                        state       <= S_ISSUE;
                    end else begin
                        state <= S_WB;
                    end
                end
                S_WB: begin
                    acc   <= '0;
                    c_cnt <= '0;
                    if (!last_neuron) begin
                        j_cnt       <= j_cnt + 1'b1;
                        addr_to_rom <= row_addr(int'(j_cnt) + 1, 0);
                        state       <= S_ISSUE;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: done <= 1'b1;
                default: state <= S_IDLE;
            endcase
        end
    end

    // No reset here: the next layer keeps reading this vector across the controller's reset pulse.
    always_ff @(posedge clk) begin
        if (state == S_WB && !abort) begin
            data_to_ram[j_cnt*DW +: DW] <= rq;
        end
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// Bench for fc_layer_engine: chunked 16-bit instance checked cycle by cycle against a dot-product
// model, plus a small binary-input instance with hand-computed expectations.
module tb_fc_layer_engine;

    localparam int IN_LEN   = 200;
    localparam int OUT_LEN  = 4;
    localparam int DW       = 16;
    localparam int FRAC     = 8;
    localparam int LANES    = 128;
    localparam int AW       = 11;
    localparam int ROM_BASE = 5;
    localparam int CHUNKS   = 2;
    localparam int PER      = 2*CHUNKS + 1;
    localparam int T_DONE   = 1 + OUT_LEN*PER;
    localparam int NROWS    = ROM_BASE + OUT_LEN*CHUNKS;

    logic clk = 1'b0;
    logic iRst_n;
    logic ena;
    logic ena_b;

    logic [LANES*DW-1:0]   data_from_rom;
    logic [IN_LEN*DW-1:0]  data_from_ram;
    logic [2*DW-2:0]       mult_sum;
    logic                  done;
    logic [AW-1:0]         addr;
    logic [LANES*DW-1:0]   opr1;
    logic [LANES*DW-1:0]   opr2;
    logic [OUT_LEN*DW-1:0] data_to_ram;

    logic [8*DW-1:0] data_from_rom_b;
    logic [11:0]     ram_b;
    logic [2*DW-2:0] mult_b;
    logic            done_b;
    logic [3:0]      addr_b;
    logic [8*DW-1:0] opr1_b;
    logic [8*DW-1:0] opr2_b;
    logic [2*DW-1:0] out_b;

    logic [LANES*DW-1:0] rom [NROWS];
    logic [8*DW-1:0]     rom_b [4];
    int                  x [IN_LEN];
    logic [DW-1:0]       exp_out [OUT_LEN];
    logic [DW-1:0]       prev_out [OUT_LEN];

    int   total = 0;
    int   bad = 0;
    logic tracking = 1'b0;
    int   edge_cnt = 0;

    always #5 clk = ~clk;

    fc_layer_engine #(
        .IN_LEN(IN_LEN), .OUT_LEN(OUT_LEN), .IN_W(16), .DW(DW), .FRAC(FRAC),
        .LANES(LANES), .AW(AW), .ROM_BASE(ROM_BASE)
    ) u_dut (
        .clk                 (clk),
        .iRst_n              (iRst_n),
        .ena                 (ena),
        .data_from_rom       (data_from_rom),
        .data_from_ram       (data_from_ram),
        .data_from_MultAdder (mult_sum),
        .done                (done),
        .addr_to_rom         (addr),
        .opr1_to_MultAdder   (opr1),
        .opr2_to_MultAdder   (opr2),
        .data_to_ram         (data_to_ram)
    );

    fc_layer_engine #(
        .IN_LEN(12), .OUT_LEN(2), .IN_W(1), .DW(DW), .FRAC(FRAC),
        .LANES(8), .AW(4), .ROM_BASE(0)
    ) u_bin (
        .clk                 (clk),
        .iRst_n              (iRst_n),
        .ena                 (ena_b),
        .data_from_rom       (data_from_rom_b),
        .data_from_ram       (ram_b),
        .data_from_MultAdder (mult_b),
        .done                (done_b),
        .addr_to_rom         (addr_b),
        .opr1_to_MultAdder   (opr1_b),
        .opr2_to_MultAdder   (opr2_b),
        .data_to_ram         (out_b)
    );

    // Weight ROMs: one-cycle read latency.
    always @(posedge clk) begin
        data_from_rom   <= (int'(addr) < NROWS) ? rom[addr] : '0;
        data_from_rom_b <= rom_b[addr_b[1:0]];
    end

    function automatic logic [2*DW-2:0] multadd(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b);
        longint s;
        s = 0;
        for (int l = 0; l < LANES; l++)
            s += longint'($signed(a[l*DW +: DW])) * longint'($signed(b[l*DW +: DW]));
        return (2*DW-1)'(s);
    endfunction

    assign mult_sum = multadd(opr1, opr2);
    assign mult_b   = multadd((LANES*DW)'(opr1_b), (LANES*DW)'(opr2_b));

    // Reference neuron: full-precision dot product, floor to Q(FRAC), clamp.
    function automatic logic [DW-1:0] model_out(input int j);
        longint s;
        longint w;
        s = 0;
        for (int i = 0; i < IN_LEN; i++) begin
            w = longint'($signed(rom[ROM_BASE + j*CHUNKS + i/LANES][(i%LANES)*DW +: DW]));
            s += w * longint'(x[i]);
        end
        s = s >>> FRAC;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        return DW'(s);
    endfunction

    function automatic logic [LANES*DW-1:0] exp_chunk(input int c);
        logic [LANES*DW-1:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++)
            if (c*LANES + l < IN_LEN) v[l*DW +: DW] = DW'(x[c*LANES + l]);
        return v;
    endfunction

    function automatic logic [OUT_LEN*DW-1:0] packed_exp(input int n_new);
        logic [OUT_LEN*DW-1:0] v;
        for (int j = 0; j < OUT_LEN; j++)
            v[j*DW +: DW] = (j < n_new) ? exp_out[j] : prev_out[j];
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_vec(input string name, input logic [LANES*DW-1:0] act, input logic [LANES*DW-1:0] expv);
        int first;
        total++;
        if (act !== expv) begin
            bad++;
            first = 0;
            for (int l = LANES - 1; l >= 0; l--)
                if (act[l*DW +: DW] !== expv[l*DW +: DW]) first = l;
            $display("FAIL %s lane %0d: got %h expected %h (t=%0t)", name, first,
                     act[first*DW +: DW], expv[first*DW +: DW], $time);
        end
    endtask

    always @(posedge clk) edge_cnt <= tracking ? edge_cnt + 1 : 0;

    // Timeline of a run: per neuron CHUNKS x (ISSUE, MAC) then one write-back cycle.
    always @(negedge clk) begin : compare
        int p, j, r;
        if (tracking && iRst_n && edge_cnt >= 1) begin
            p = edge_cnt - 1;
            if (edge_cnt < T_DONE) begin
                j = p / PER;
                r = p % PER;
                chk("done_low", done, 0);
                if (r < 2*CHUNKS) chk("addr", addr, ROM_BASE + j*CHUNKS + r/2);
                if (r < 2*CHUNKS && r % 2 == 1) begin
                    chk_vec("opr1_mac", opr1, rom[ROM_BASE + j*CHUNKS + r/2]);
                    chk_vec("opr2_mac", opr2, exp_chunk(r/2));
                end else begin
                    chk_vec("opr1_idle", opr1, '0);
                    chk_vec("opr2_idle", opr2, '0);
                end
            end else begin
                chk("done_high", done, 1);
                chk_vec("opr1_done", opr1, '0);
            end
            if (edge_cnt >= 2 && (edge_cnt - 2) % PER == 2*CHUNKS) begin
                j = (edge_cnt - 2) / PER;
                chk("slot", data_to_ram[j*DW +: DW], exp_out[j]);
            end
        end
    end

    task automatic set_ram();
        for (int i = 0; i < IN_LEN; i++) data_from_ram[i*DW +: DW] = DW'(x[i]);
    endtask

    task automatic update_model();
        for (int j = 0; j < OUT_LEN; j++) begin
            prev_out[j] = exp_out[j];
            exp_out[j]  = model_out(j);
        end
    endtask

    task automatic fill_random(input int mag);
        for (int r = 0; r < NROWS; r++)
            for (int l = 0; l < LANES; l++)
                rom[r][l*DW +: DW] = DW'($urandom_range(0, 2*mag) - mag);
        for (int i = 0; i < IN_LEN; i++) x[i] = int'($urandom_range(0, 2*mag)) - mag;
        set_ram();
    endtask

    task automatic start_run();
        @(negedge clk);
        ena = 1'b1;
        tracking = 1'b1;
    endtask

    task automatic run_and_check();
        start_run();
        repeat (T_DONE + 1) @(negedge clk);
        tracking = 1'b0;
        chk("final_vec", data_to_ram, packed_exp(OUT_LEN));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        ena = 1'b0;
        #1 iRst_n = 1'b0;
        #2;
        chk("rst_done", done, 0);
        chk("rst_addr", addr, 0);
        chk("rst_keeps_out", data_to_ram, packed_exp(OUT_LEN));
        @(negedge clk);
        iRst_n = 1'b1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got still running expected finished");
        $fatal(1);
    end

    initial begin
        int mags [3];
        mags[0] = 255; mags[1] = 2047; mags[2] = 40;
        iRst_n = 1'b1;
        ena = 1'b0;
        ena_b = 1'b0;
        ram_b = 12'hAAA;
        data_from_ram = '0;
        for (int r = 0; r < NROWS; r++) rom[r] = '0;
        for (int j = 0; j < OUT_LEN; j++) exp_out[j] = '0;
        #2 iRst_n = 1'b0;
        #10;
        chk("reset_done", done, 0);
        chk("reset_addr", addr, 0);
        chk_vec("reset_opr1", opr1, '0);
        chk_vec("reset_opr2", opr2, '0);
        chk("reset_done_b", done_b, 0);
        @(negedge clk);
        iRst_n = 1'b1;

        // All ones: 200 x 1.0 saturates.
        for (int r = 0; r < NROWS; r++)
            for (int l = 0; l < LANES; l++) rom[r][l*DW +: DW] = 16'h0100;
        for (int i = 0; i < IN_LEN; i++) x[i] = 256;
        set_ram();
        update_model();
        chk("pin_ones", exp_out[0], 16'h7FFF);
        run_and_check();
        chk("ones_out3", data_to_ram[3*DW +: DW], 16'h7FFF);
        pulse_reset();

        // Directed signs, flooring, and a weight on a padded lane.
        for (int r = 0; r < NROWS; r++) rom[r] = '0;
        for (int i = 0; i < IN_LEN; i++) x[i] = 256;
        x[5] = 3;
        rom[ROM_BASE + 0][0*DW +: DW]   = 16'hFFFF;
        rom[ROM_BASE + 0][1*DW +: DW]   = 16'hFFFF;
        rom[ROM_BASE + 2][0*DW +: DW]   = 16'h0080;
        rom[ROM_BASE + 4][5*DW +: DW]   = 16'hFFFF;
        rom[ROM_BASE + 7][2*DW +: DW]   = 16'h0300;
        rom[ROM_BASE + 7][100*DW +: DW] = 16'h7FFF;
        set_ram();
        update_model();
`ifdef FC_RELU_EN
        chk("pin_neg", exp_out[0], 16'h0000);
        chk("pin_floor", exp_out[2], 16'h0000);
`else
        chk("pin_neg", exp_out[0], 16'hFFFE);
        chk("pin_floor", exp_out[2], 16'hFFFF);
`endif
        chk("pin_half", exp_out[1], 16'h0080);
        chk("pin_chunk1", exp_out[3], 16'h0300);
        run_and_check();
        ena = 1'b0;
        repeat (3) @(negedge clk);
        chk("done_hold_ena_low", done, 1);
        pulse_reset();

        for (int k = 0; k < 3; k++) begin
            fill_random(mags[k]);
            update_model();
            run_and_check();
            pulse_reset();
        end

        // Abort after the first neuron's write-back.
        fill_random(1000);
        update_model();
        start_run();
        repeat (7) @(negedge clk);
        ena = 1'b0;
        tracking = 1'b0;
        @(negedge clk);
        chk("abort_done", done, 0);
        chk_vec("abort_opr1", opr1, '0);
        chk("abort_partial", data_to_ram, packed_exp(1));
        repeat (2) @(negedge clk);
        chk("abort_done_later", done, 0);
        run_and_check();
        pulse_reset();

        // Reset in the middle of a run.
        fill_random(600);
        update_model();
        start_run();
        repeat (12) @(negedge clk);
        tracking = 1'b0;
        ena = 1'b0;
        #1 iRst_n = 1'b0;
        #2;
        chk("midrst_done", done, 0);
        chk("midrst_addr", addr, 0);
        chk("midrst_out", data_to_ram, packed_exp(2));
        @(negedge clk);
        iRst_n = 1'b1;
        run_and_check();
        pulse_reset();

        // Binary instance: pattern 0xAAA, 12 inputs over two 8-lane chunks.
        for (int l = 0; l < 8; l++) begin
            rom_b[0][l*DW +: DW] = 16'h0100;
            rom_b[1][l*DW +: DW] = 16'h0100;
            rom_b[2][l*DW +: DW] = 16'hFF00;
            rom_b[3][l*DW +: DW] = 16'hFF00;
        end
        @(negedge clk);
        ena_b = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (t == 2) begin
                chk("bin_c0_lo", opr2_b[63:0],   64'h0100_0000_0100_0000);
                chk("bin_c0_hi", opr2_b[127:64], 64'h0100_0000_0100_0000);
            end
            if (t == 4) begin
                chk("bin_c1_lo", opr2_b[63:0],   64'h0100_0000_0100_0000);
                chk("bin_c1_pad", opr2_b[127:64], 64'h0);
            end
            if (t == 10) chk("bin_done_low", done_b, 0);
            if (t == 11) chk("bin_done_high", done_b, 1);
        end
`ifdef FC_RELU_EN
        chk("bin_out", out_b, 32'h0000_0600);
`else
        chk("bin_out", out_b, 32'hFA00_0600);
`endif
        ena_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
